// File: rtl/rv_width_adapter.sv
// Byte/word width adapter: packs transport bytes into bus words and unpacks
// bus words into transport bytes, each direction with its own ready/valid FSM.
module rv_width_adapter #(
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                  CLK_I,
    input  logic                  RST_NI,
    input  logic                  CLEAR_I,
    input  logic                  RX_VALID_I,
    output logic                  RX_READY_O,
    input  logic [BYTE_WIDTH-1:0] RX_DATA_I,
    output logic                  WORD_VALID_O,
    input  logic                  WORD_READY_I,
    output logic [WORD_WIDTH-1:0] WORD_DATA_O,
    input  logic                  WORD_VALID_I,
    output logic                  WORD_READY_O,
    input  logic [WORD_WIDTH-1:0] WORD_DATA_I,
    output logic                  TX_VALID_O,
    input  logic                  TX_READY_I,
    output logic [BYTE_WIDTH-1:0] TX_DATA_O
);

    localparam int unsigned N  = WORD_WIDTH / BYTE_WIDTH;
    localparam int unsigned CW = $clog2(N);

    typedef enum logic {PK_COLLECT, PK_HOLD} pk_state_e;
    typedef enum logic {UP_IDLE, UP_SEND} up_state_e;

    pk_state_e             pk_state_q, pk_state_d;
    logic [CW-1:0]         pk_cnt_q, pk_cnt_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic                  rx_ready_q, rx_ready_d;
    logic                  word_valid_q, word_valid_d;

    up_state_e             up_state_q, up_state_d;
    logic [CW-1:0]         up_cnt_q, up_cnt_d;
    logic [WORD_WIDTH-1:0] sh_q, sh_d;
    logic                  word_ready_q, word_ready_d;
    logic                  tx_valid_q, tx_valid_d;

    // Pack path: while collecting, ready is high so a valid byte is a handshake.
    always_comb begin
        pk_state_d = pk_state_q;
        pk_cnt_d   = pk_cnt_q;
        word_d     = word_q;
        if (CLEAR_I) begin
            pk_state_d = PK_COLLECT;
            pk_cnt_d   = '0;
            word_d     = '0;
        end else begin
            case (pk_state_q)
                PK_COLLECT: begin
                    if (RX_VALID_I) begin
                        word_d[pk_cnt_q*BYTE_WIDTH +: BYTE_WIDTH] = RX_DATA_I;
                        if (pk_cnt_q == CW'(N-1)) begin
                            pk_cnt_d   = '0;
                            pk_state_d = PK_HOLD;
                        end else begin
                            pk_cnt_d = pk_cnt_q + CW'(1);
                        end
                    end
                end
                PK_HOLD: begin
                    if (WORD_READY_I) pk_state_d = PK_COLLECT;
                end
                default: pk_state_d = PK_COLLECT;
            endcase
        end
        rx_ready_d   = (pk_state_d == PK_COLLECT);
        word_valid_d = (pk_state_d == PK_HOLD);
    end

    // Unpack path: the captured word shifts right so the current byte is always the LSBs.
    always_comb begin
        up_state_d = up_state_q;
        up_cnt_d   = up_cnt_q;
        sh_d       = sh_q;
        if (CLEAR_I) begin
            up_state_d = UP_IDLE;
            up_cnt_d   = '0;
            sh_d       = '0;
        end else begin
            case (up_state_q)
                UP_IDLE: begin
                    if (WORD_VALID_I) begin
                        sh_d       = WORD_DATA_I;
                        up_cnt_d   = '0;
                        up_state_d = UP_SEND;
                    end
                end
                UP_SEND: begin
                    if (TX_READY_I) begin
                        sh_d = sh_q >> BYTE_WIDTH;
                        if (up_cnt_q == CW'(N-1)) begin
                            up_cnt_d   = '0;
                            up_state_d = UP_IDLE;
                        end else begin
                            up_cnt_d = up_cnt_q + CW'(1);
                        end
                    end
                end
                default: up_state_d = UP_IDLE;
            endcase
        end
        word_ready_d = (up_state_d == UP_IDLE);
        tx_valid_d   = (up_state_d == UP_SEND);
    end

    always_ff @(posedge CLK_I) begin
        if (!RST_NI) begin
            pk_state_q   <= PK_COLLECT;
            pk_cnt_q     <= '0;
            word_q       <= '0;
            rx_ready_q   <= 1'b1;
            word_valid_q <= 1'b0;
            up_state_q   <= UP_IDLE;
            up_cnt_q     <= '0;
            sh_q         <= '0;
            word_ready_q <= 1'b1;
            tx_valid_q   <= 1'b0;
        end else begin
            pk_state_q   <= pk_state_d;
            pk_cnt_q     <= pk_cnt_d;
            word_q       <= word_d;
            rx_ready_q   <= rx_ready_d;
            word_valid_q <= word_valid_d;
            up_state_q   <= up_state_d;
            up_cnt_q     <= up_cnt_d;
            sh_q         <= sh_d;
            word_ready_q <= word_ready_d;
            tx_valid_q   <= tx_valid_d;
        end
    end

    assign RX_READY_O   = rx_ready_q;
    assign WORD_VALID_O = word_valid_q;
    assign WORD_DATA_O  = word_q;
    assign WORD_READY_O = word_ready_q;
    assign TX_VALID_O   = tx_valid_q;
    assign TX_DATA_O    = sh_q[BYTE_WIDTH-1:0];

endmodule

// File: tb/tb_rv_width_adapter.sv
// Bench for rv_width_adapter: cycle table for the pack path, hand sequences
// for unpack/reset, and a queue scoreboard for concurrent random traffic.
module tb_rv_width_adapter;

    logic        CLK_I, RST_NI, CLEAR_I;
    logic        RX_VALID_I, RX_READY_O;
    logic [7:0]  RX_DATA_I;
    logic        WORD_VALID_O, WORD_READY_I;
    logic [31:0] WORD_DATA_O;
    logic        WORD_VALID_I, WORD_READY_O;
    logic [31:0] WORD_DATA_I;
    logic        TX_VALID_O, TX_READY_I;
    logic [7:0]  TX_DATA_O;

    rv_width_adapter #(.BYTE_WIDTH(8), .WORD_WIDTH(32)) dut (
        .CLK_I(CLK_I), .RST_NI(RST_NI), .CLEAR_I(CLEAR_I),
        .RX_VALID_I(RX_VALID_I), .RX_READY_O(RX_READY_O), .RX_DATA_I(RX_DATA_I),
        .WORD_VALID_O(WORD_VALID_O), .WORD_READY_I(WORD_READY_I), .WORD_DATA_O(WORD_DATA_O),
        .WORD_VALID_I(WORD_VALID_I), .WORD_READY_O(WORD_READY_O), .WORD_DATA_I(WORD_DATA_I),
        .TX_VALID_O(TX_VALID_O), .TX_READY_I(TX_READY_I), .TX_DATA_O(TX_DATA_O)
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    typedef struct {
        bit        clr;
        bit        rv;
        bit [7:0]  rd;
        bit        wr;
        bit        e_rdy;
        bit        e_wv;
        bit [31:0] e_wd;
    } vec_t;

    vec_t     vecs[$];
    bit [7:0] tx_q[$];
    bit [31:0] word_q[$];
    int       checks = 0;
    int       failures = 0;
    int       tx_hs_cnt = 0;
    bit       mon_word_en = 1'b0;
    bit       pk_done, up_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic add(input bit clr, input bit rv, input bit [7:0] rd, input bit wr,
                       input bit e_rdy, input bit e_wv, input bit [31:0] e_wd);
        vec_t v;
        v.clr = clr; v.rv = rv; v.rd = rd; v.wr = wr;
        v.e_rdy = e_rdy; v.e_wv = e_wv; v.e_wd = e_wd;
        vecs.push_back(v);
    endtask

    // Handshakes are observed mid-cycle, where they predict the next rising edge.
    task automatic monitor();
        bit [7:0]  eb;
        bit [31:0] ew;
        forever begin
            @(negedge CLK_I);
            if (RST_NI && !CLEAR_I) begin
                if (TX_VALID_O && TX_READY_I) begin
                    tx_hs_cnt++;
                    if (tx_q.size() == 0) check("tx_unexpected", 32'(TX_DATA_O), 32'hFFFF_FFFF);
                    else begin
                        eb = tx_q.pop_front();
                        check("tx_byte", 32'(TX_DATA_O), 32'(eb));
                    end
                end
                if (mon_word_en && WORD_VALID_O && WORD_READY_I) begin
                    if (word_q.size() == 0) check("word_unexpected", WORD_DATA_O, 32'hDEAD_0000);
                    else begin
                        ew = word_q.pop_front();
                        check("word_data", WORD_DATA_O, ew);
                    end
                end
            end
        end
    endtask

    initial begin
        bit hs_word, last, done, tgl;
        int base;
        fork monitor(); join_none

        RST_NI = 1'b0; CLEAR_I = 1'b0;
        RX_VALID_I = 1'b0; RX_DATA_I = 8'h00; WORD_READY_I = 1'b0;
        WORD_VALID_I = 1'b0; WORD_DATA_I = 32'h0; TX_READY_I = 1'b0;
        step(); step();
        check("rst_rx_ready", 32'(RX_READY_O), 32'd1);
        check("rst_word_valid", 32'(WORD_VALID_O), 32'd0);
        check("rst_word_data", WORD_DATA_O, 32'd0);
        check("rst_word_ready", 32'(WORD_READY_O), 32'd1);
        check("rst_tx_valid", 32'(TX_VALID_O), 32'd0);
        check("rst_tx_data", 32'(TX_DATA_O), 32'd0);
        RST_NI = 1'b1;

        // Back-to-back word with immediate downstream ready.
        add(1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 32'h0000_0011);
        add(1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 32'h0000_2211);
        add(1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 32'h0033_2211);
        add(1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 32'h4433_2211);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h4433_2211);
        // Downstream stalls; a pending fifth byte waits for the word handshake.
        add(1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 32'h4433_2211);
        add(1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 32'h4433_2211);
        add(1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 32'h4433_2211);
        add(1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 32'h4433_2211);
        for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 32'h4433_2211);
        add(1'b0, 1'b1, 8'h99, 1'b1, 1'b1, 1'b0, 32'h4433_2211);
        add(1'b0, 1'b1, 8'h99, 1'b0, 1'b1, 1'b0, 32'h4433_2299);
        add(1'b0, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 32'h4433_AA99);
        add(1'b0, 1'b1, 8'hBB, 1'b0, 1'b1, 1'b0, 32'h44BB_AA99);
        add(1'b0, 1'b1, 8'hCC, 1'b0, 1'b0, 1'b1, 32'hCCBB_AA99);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'hCCBB_AA99);
        // Clear mid-word; the byte offered with clear is ignored.
        add(1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 32'hCCBB_AA55);
        add(1'b0, 1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 32'hCCBB_6655);
        add(1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 32'h0000_0000);
        add(1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 32'h0000_0001);
        add(1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 32'h0000_0201);
        add(1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 32'h0003_0201);
        add(1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 32'h0403_0201);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0403_0201);

        for (int i = 0; i < vecs.size(); i++) begin
            CLEAR_I = vecs[i].clr; RX_VALID_I = vecs[i].rv;
            RX_DATA_I = vecs[i].rd; WORD_READY_I = vecs[i].wr;
            step();
            check($sformatf("vec%0d_rx_ready", i), 32'(RX_READY_O), 32'(vecs[i].e_rdy));
            check($sformatf("vec%0d_word_valid", i), 32'(WORD_VALID_O), 32'(vecs[i].e_wv));
            check($sformatf("vec%0d_word_data", i), WORD_DATA_O, vecs[i].e_wd);
        end
        CLEAR_I = 1'b0; RX_VALID_I = 1'b0; WORD_READY_I = 1'b0;

        // Unpack with TX ready toggling.
        tx_q.push_back(8'hD4); tx_q.push_back(8'hC3); tx_q.push_back(8'hB2); tx_q.push_back(8'hA1);
        WORD_DATA_I = 32'hA1B2_C3D4; WORD_VALID_I = 1'b1;
        base = tx_hs_cnt; done = 1'b0; tgl = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            TX_READY_I = tgl; tgl = ~tgl;
            hs_word = WORD_VALID_I && WORD_READY_O;
            last = TX_VALID_O && TX_READY_I && (tx_hs_cnt == base + 3);
            step();
            if (hs_word) begin
                WORD_VALID_I = 1'b0;
                check("send_word_ready", 32'(WORD_READY_O), 32'd0);
                check("send_tx_valid", 32'(TX_VALID_O), 32'd1);
            end
            if (last) begin
                check("after_last_word_ready", 32'(WORD_READY_O), 32'd1);
                check("after_last_tx_valid", 32'(TX_VALID_O), 32'd0);
                done = 1'b1;
            end
        end
        if (!done) check("unpack_timeout", 32'd0, 32'd1);
        check("unpack_drained", 32'(tx_q.size()), 32'd0);
        TX_READY_I = 1'b0;

        // Reset in the middle of sending; remaining bytes are dropped.
        tx_q.push_back(8'h0D); tx_q.push_back(8'h0C); tx_q.push_back(8'h0B); tx_q.push_back(8'h0A);
        WORD_DATA_I = 32'h0A0B_0C0D; WORD_VALID_I = 1'b1; TX_READY_I = 1'b1;
        base = tx_hs_cnt;
        for (int c = 0; c < 40 && tx_hs_cnt < base + 2; c++) begin
            hs_word = WORD_VALID_I && WORD_READY_O;
            step();
            if (hs_word) WORD_VALID_I = 1'b0;
        end
        check("rst_mid_sent2", 32'(tx_hs_cnt - base), 32'd2);
        RST_NI = 1'b0; TX_READY_I = 1'b0; WORD_VALID_I = 1'b0;
        tx_q.delete();
        step();
        check("rst_mid_tx_valid", 32'(TX_VALID_O), 32'd0);
        check("rst_mid_word_ready", 32'(WORD_READY_O), 32'd1);
        RST_NI = 1'b1;
        tx_q.push_back(8'h8D); tx_q.push_back(8'h7C); tx_q.push_back(8'h6B); tx_q.push_back(8'h5A);
        WORD_DATA_I = 32'h5A6B_7C8D; WORD_VALID_I = 1'b1; TX_READY_I = 1'b1;
        for (int c = 0; c < 40 && tx_q.size() != 0; c++) begin
            hs_word = WORD_VALID_I && WORD_READY_O;
            step();
            if (hs_word) WORD_VALID_I = 1'b0;
        end
        check("rst_restart_drained", 32'(tx_q.size()), 32'd0);
        WORD_VALID_I = 1'b0; TX_READY_I = 1'b0;
        step();

        // Concurrent random traffic on both paths.
        mon_word_en = 1'b1; pk_done = 1'b0; up_done = 1'b0;
        fork
            begin
                bit [31:0] wd;
                bit hs;
                for (int w = 0; w < 8; w++) begin
                    wd = $urandom;
                    word_q.push_back(wd);
                    for (int b = 0; b < 4; b++) begin
                        while ($urandom_range(0, 2) == 0) step();
                        RX_VALID_I = 1'b1; RX_DATA_I = wd[b*8 +: 8];
                        hs = 1'b0;
                        for (int g = 0; g < 200 && !hs; g++) begin
                            hs = RX_READY_O;
                            step();
                        end
                        if (!hs) check("pack_stall_timeout", 32'd0, 32'd1);
                        RX_VALID_I = 1'b0;
                    end
                end
                pk_done = 1'b1;
            end
            begin
                bit [31:0] wd;
                bit hs;
                for (int w = 0; w < 8; w++) begin
                    wd = $urandom;
                    while ($urandom_range(0, 2) == 0) step();
                    for (int b = 0; b < 4; b++) tx_q.push_back(wd[b*8 +: 8]);
                    WORD_VALID_I = 1'b1; WORD_DATA_I = wd;
                    hs = 1'b0;
                    for (int g = 0; g < 200 && !hs; g++) begin
                        hs = WORD_READY_O;
                        step();
                    end
                    if (!hs) check("unpack_stall_timeout", 32'd0, 32'd1);
                    WORD_VALID_I = 1'b0;
                end
                up_done = 1'b1;
            end
            begin
                for (int c = 0; c < 4000; c++) begin
                    if (pk_done && up_done && word_q.size() == 0 && tx_q.size() == 0) break;
                    WORD_READY_I = 1'($urandom_range(0, 1));
                    TX_READY_I = 1'($urandom_range(0, 1));
                    step();
                end
            end
        join
        WORD_READY_I = 1'b0; TX_READY_I = 1'b0;
        check("rand_pack_done", 32'(pk_done), 32'd1);
        check("rand_unpack_done", 32'(up_done), 32'd1);
        check("rand_word_drained", 32'(word_q.size()), 32'd0);
        check("rand_tx_drained", 32'(tx_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
